// File: rtl/frexpf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frexpf                                                          |
// | Purpose  : Splits an IEEE-754 single into exponent and [0.5,1) mantissa,    |
// |            with a fixed-latency pipeline feeding an eager two-way fork.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module frexpf #(
  parameter int DATA_TYPE = 32,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] exp_out,
  output logic                 exp_out_valid,
  input  logic                 exp_out_ready,
  output logic [DATA_TYPE-1:0] mant_out,
  output logic                 mant_out_valid,
  input  logic                 mant_out_ready
);

  localparam logic [7:0]           c_EXP_HALF = 8'd126;
  localparam logic [DATA_TYPE-1:0] c_BIAS     = DATA_TYPE'(126);

  logic                 w_sign;
  logic [7:0]           w_e;
  logic [22:0]          w_f;
  logic [DATA_TYPE-1:0] w_exp;
  logic [DATA_TYPE-1:0] w_mant;

  assign w_sign = ins[31];
  assign w_e    = ins[30:23];
  assign w_f    = ins[22:0];

  // Zero/subnormal flush to signed zero; inf/NaN pass through untouched.
  always_comb begin
    w_exp  = '0;
    w_mant = '0;
    if (w_e == 8'd0) begin
      w_mant = {w_sign, 31'b0};
    end else if (w_e == 8'hFF) begin
      w_mant = ins;
    end else begin
      w_exp  = {{(DATA_TYPE-8){1'b0}}, w_e} - c_BIAS;
      w_mant = {w_sign, c_EXP_HALF, w_f};
    end
  end

  logic [LATENCY-1:0]                r_v;
  logic [LATENCY-1:0][DATA_TYPE-1:0] r_exp;
  logic [LATENCY-1:0][DATA_TYPE-1:0] r_mant;
  logic                              r_sent_e;
  logic                              r_sent_m;

  logic w_last_v;
  logic w_done;
  logic w_ce;

  assign w_last_v       = r_v[LATENCY-1];
  assign exp_out_valid  = w_last_v && !r_sent_e;
  assign mant_out_valid = w_last_v && !r_sent_m;
  assign exp_out        = r_exp[LATENCY-1];
  assign mant_out       = r_mant[LATENCY-1];

  // The token retires once each side has either already taken it or takes it now.
  assign w_done    = w_last_v && (r_sent_e || exp_out_ready) && (r_sent_m || mant_out_ready);
  assign w_ce      = !w_last_v || w_done;
  assign ins_ready = w_ce;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v    <= '0;
      r_exp  <= '0;
      r_mant <= '0;
    end else if (w_ce) begin
      r_v[0]    <= ins_valid;
      r_exp[0]  <= w_exp;
      r_mant[0] <= w_mant;
      for (int k = 1; k < LATENCY; k++) begin
        r_v[k]    <= r_v[k-1];
        r_exp[k]  <= r_exp[k-1];
        r_mant[k] <= r_mant[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sent_e <= 1'b0;
      r_sent_m <= 1'b0;
    end else if (w_done) begin
      r_sent_e <= 1'b0;
      r_sent_m <= 1'b0;
    end else begin
      if (exp_out_valid && exp_out_ready) r_sent_e <= 1'b1;
      if (mant_out_valid && mant_out_ready) r_sent_m <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frexpf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_frexpf                                                       |
// | Purpose  : Directed and random checks of frexpf against a value model.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_frexpf;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ins;
  logic         ins_valid;
  logic         ins_ready;
  logic [W-1:0] exp_out;
  logic         exp_out_valid;
  logic         exp_out_ready;
  logic [W-1:0] mant_out;
  logic         mant_out_valid;
  logic         mant_out_ready;

  frexpf #(.DATA_TYPE(W), .LATENCY(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .ins            (ins),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .exp_out        (exp_out),
    .exp_out_valid  (exp_out_valid),
    .exp_out_ready  (exp_out_ready),
    .mant_out       (mant_out),
    .mant_out_valid (mant_out_valid),
    .mant_out_ready (mant_out_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mant_q[$];

  logic         prev_ev = 1'b0, prev_mv = 1'b0, prev_et = 1'b0, prev_mt = 1'b0;
  logic [W-1:0] prev_e = '0, prev_m = '0;

  // frexp on the value: x = m * 2^k with |m| in [0.5,1); m carries biased exponent 126.
  function automatic logic [W-1:0] ref_exp(logic [W-1:0] x);
    int be;
    be = int'(x[30:23]);
    if (be == 0 || be == 255) return '0;
    return W'((be - 127) + 1);
  endfunction

  function automatic logic [W-1:0] ref_mant(logic [W-1:0] x);
    int be;
    be = int'(x[30:23]);
    if (be == 0)   return x & 32'h8000_0000;
    if (be == 255) return x;
    return (x & 32'h807F_FFFF) | (32'(126) << 23);
  endfunction

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(logic [W-1:0] x, logic v);
    ins       = x;
    ins_valid = v;
  endtask

  // Scoreboard and hold checks at the falling edge, between active edges.
  task automatic at_neg();
    @(negedge clk);
    if (prev_ev && !prev_et) begin
      check("exp_hold_valid", 32'(exp_out_valid), 32'd1);
      check("exp_hold_data", exp_out, prev_e);
    end
    if (prev_mv && !prev_mt) begin
      check("mant_hold_valid", 32'(mant_out_valid), 32'd1);
      check("mant_hold_data", mant_out, prev_m);
    end
    if (ins_valid && ins_ready) begin
      exp_q.push_back(ref_exp(ins));
      mant_q.push_back(ref_mant(ins));
      n_acc++;
    end
    if (exp_out_valid && exp_out_ready) begin
      if (exp_q.size() == 0) check("exp_extra", 32'(exp_out_valid), 32'd0);
      else check("exp_data", exp_out, exp_q.pop_front());
    end
    if (mant_out_valid && mant_out_ready) begin
      if (mant_q.size() == 0) check("mant_extra", 32'(mant_out_valid), 32'd0);
      else check("mant_data", mant_out, mant_q.pop_front());
    end
    prev_ev = exp_out_valid;  prev_et = exp_out_valid && exp_out_ready;  prev_e = exp_out;
    prev_mv = mant_out_valid; prev_mt = mant_out_valid && mant_out_ready; prev_m = mant_out;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      drive('0, 1'b0);
      at_neg();
      to_next();
    end
  endtask

  // One token, both sides ready: outputs must appear exactly LAT cycles after acceptance.
  task automatic send_and_time(logic [W-1:0] x);
    exp_out_ready  = 1'b1;
    mant_out_ready = 1'b1;
    drive(x, 1'b1);
    at_neg();
    check("lat_accept", 32'(ins_ready), 32'd1);
    to_next();
    for (int k = 1; k <= LAT; k++) begin
      drive('0, 1'b0);
      at_neg();
      check("lat_exp_valid", 32'(exp_out_valid), 32'(k == LAT));
      check("lat_mant_valid", 32'(mant_out_valid), 32'(k == LAT));
      if (k == LAT) begin
        check("lat_exp_val", exp_out, ref_exp(x));
        check("lat_mant_val", mant_out, ref_mant(x));
      end
      to_next();
    end
  endtask

  initial begin
    logic [W-1:0] vals[7];
    int           cyc;

    rst = 1'b0;
    drive('0, 1'b0);
    exp_out_ready  = 1'b1;
    mant_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_exp_valid", 32'(exp_out_valid), 32'd0);
    check("rst_mant_valid", 32'(mant_out_valid), 32'd0);
    check("rst_exp_out", exp_out, 32'd0);
    check("rst_mant_out", mant_out, 32'd0);
    check("rst_ins_ready", 32'(ins_ready), 32'd1);
    #2 rst = 1'b1;
    to_next();

    // 1.0 -> exp 1, mant 0.5
    send_and_time(32'h3F80_0000);
    check("one_exp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back normals then specials, both consumers ready.
    vals[0] = 32'h4100_0000; vals[1] = 32'hC040_0000; vals[2] = 32'h0100_0000;
    vals[3] = 32'h0000_0001; vals[4] = 32'h8000_0000; vals[5] = 32'h7F80_0000;
    vals[6] = 32'h7FC0_0001;
    for (int i = 0; i < 7; i++) begin
      drive(vals[i], 1'b1);
      at_neg();
      check("b2b_ready", 32'(ins_ready), 32'd1);
      to_next();
    end
    idle(LAT + 2);
    check("b2b_exp_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_mant_drained", 32'(mant_q.size()), 32'd0);

    // Eager fork: exp side ready, mant side stalled three cycles.
    exp_out_ready  = 1'b1;
    mant_out_ready = 1'b0;
    drive(32'h4100_0000, 1'b1);
    at_neg(); to_next();
    drive(32'hC040_0000, 1'b1);
    at_neg(); to_next();
    drive('0, 1'b0);
    at_neg();
    check("fork_first_ev", 32'(exp_out_valid), 32'd1);
    check("fork_first_mv", 32'(mant_out_valid), 32'd1);
    check("fork_first_ready", 32'(ins_ready), 32'd0);
    to_next();
    for (int i = 0; i < 2; i++) begin
      at_neg();
      check("fork_stall_ev", 32'(exp_out_valid), 32'd0);
      check("fork_stall_mv", 32'(mant_out_valid), 32'd1);
      check("fork_stall_ready", 32'(ins_ready), 32'd0);
      to_next();
    end
    mant_out_ready = 1'b1;
    at_neg();
    check("fork_release_ready", 32'(ins_ready), 32'd1);
    to_next();
    at_neg();
    check("fork_next_ev", 32'(exp_out_valid), 32'd1);
    check("fork_next_mv", 32'(mant_out_valid), 32'd1);
    check("fork_next_exp", exp_out, 32'd2);
    to_next();
    idle(LAT + 2);
    check("fork_drained", 32'(exp_q.size() + mant_q.size()), 32'd0);

    // Random stress with independent valid/ready patterns.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      logic [W-1:0] r;
      r = $urandom;
      case ($urandom_range(7))
        0: r[30:23] = 8'd0;
        1: r[30:23] = 8'hFF;
        2: r[30:23] = 8'd1;
        3: r[30:23] = 8'hFE;
        default: ;
      endcase
      drive(r, $urandom_range(3) != 0);
      exp_out_ready  = $urandom_range(3) != 0;
      mant_out_ready = $urandom_range(3) != 0;
      at_neg();
      to_next();
      cyc++;
    end
    check("rand_token_count", 32'(n_acc), 32'd10000);
    exp_out_ready  = 1'b1;
    mant_out_ready = 1'b1;
    idle(LAT + 3);
    check("rand_exp_drained", 32'(exp_q.size()), 32'd0);
    check("rand_mant_drained", 32'(mant_q.size()), 32'd0);

    // Reset with two tokens in flight.
    exp_out_ready  = 1'b0;
    mant_out_ready = 1'b0;
    drive(32'h4000_0000, 1'b1);
    at_neg(); to_next();
    drive(32'h4040_0000, 1'b1);
    at_neg(); to_next();
    drive('0, 1'b0);
    at_neg();
    check("mid_pre_ev", 32'(exp_out_valid), 32'd1);
    to_next();
    #2 rst = 1'b0;
    #1;
    check("mid_async_ev", 32'(exp_out_valid), 32'd0);
    check("mid_async_mv", 32'(mant_out_valid), 32'd0);
    exp_q.delete();
    mant_q.delete();
    prev_ev = 1'b0; prev_mv = 1'b0;
    at_neg(); to_next();
    #3 rst = 1'b1;
    exp_out_ready  = 1'b1;
    mant_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive('0, 1'b0);
      at_neg();
      check("mid_post_ev", 32'(exp_out_valid), 32'd0);
      check("mid_post_mv", 32'(mant_out_valid), 32'd0);
      to_next();
    end
    send_and_time(32'hBE80_0000);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
